// File: rtl/adc_scan_ctrl_pkg.sv
// Shared definitions for the ADC scan controller: FSM encoding, default
// timing parameters and the channel count.
package adc_scan_ctrl_pkg;

  localparam int          NUM_CH         = 2;
  localparam logic [15:0] SAMPLE_DIV_DEF = 16'd5000;
  localparam logic [11:0] TIMEOUT_DEF    = 12'd2000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_LATCH     = 3'd4
  } scan_state_t;

  // Lowest set channel wins, so channel 0 is always converted first.
  function automatic logic first_channel(input logic [NUM_CH-1:0] mask);
    return mask[0] ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/adc_scan_ctrl_tick.sv
// Scan period generator: one-cycle sample_tick every SAMPLE_DIV sysclk
// cycles while enabled; parked at the reload value while disabled.
module sample_tick_gen
  import adc_scan_ctrl_pkg::*;
#(
  parameter logic [15:0] SAMPLE_DIV = SAMPLE_DIV_DEF
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic enable,
  output logic sample_tick
);

  localparam logic [15:0] RELOAD = SAMPLE_DIV - 16'd1;

  logic [15:0] r_count;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_count <= RELOAD;
    end else if (!enable) begin
      r_count <= RELOAD;
    end else if (r_count == 16'd0) begin
      r_count <= RELOAD;
    end else begin
      r_count <= r_count - 16'd1;
    end
  end

  assign sample_tick = enable && (r_count == 16'd0);

endmodule

// File: rtl/adc_scan_ctrl.sv
// Periodic two-channel ADC scan sequencer: issues start pulses to an SPI ADC
// front end, tracks its chip-select handshake and latches results per channel.
module adc_scan_ctrl
  import adc_scan_ctrl_pkg::*;
#(
  parameter logic [15:0] SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter logic [11:0] TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  ch_mask,
  input  logic        clr_flags,
  output logic        adc_start,
  output logic        adc_channel,
  input  logic [9:0]  adc_data,
  input  logic        adc_data_valid,
  output logic [9:0]  ch0_data,
  output logic [9:0]  ch1_data,
  output logic        ch0_new,
  output logic        ch1_new,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);

  localparam logic [11:0] WAIT_LAST = TIMEOUT - 12'd1;

  scan_state_t r_state;
  logic [NUM_CH-1:0] r_scan_mask;
  logic        r_channel;
  logic [11:0] r_wait_cnt;
  logic        r_start;
  logic [9:0]  r_ch0_data;
  logic [9:0]  r_ch1_data;
  logic        r_ch0_new;
  logic        r_ch1_new;
  logic        r_overrun;
  logic        r_timeout;

  logic              w_tick;
  logic [NUM_CH-1:0] w_remaining;

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sample_tick(w_tick)
  );

  // Channels still owed a conversion once the current one is latched.
  assign w_remaining = r_scan_mask & (r_channel ? 2'b00 : 2'b10);

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_scan_mask <= '0;
      r_channel   <= 1'b0;
      r_wait_cnt  <= 12'd0;
      r_start     <= 1'b0;
      r_ch0_data  <= 10'd0;
      r_ch1_data  <= 10'd0;
      r_ch0_new   <= 1'b0;
      r_ch1_new   <= 1'b0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      r_ch0_new <= 1'b0;
      r_ch1_new <= 1'b0;

      // Clear first so a same-cycle error event still leaves the flag set.
      if (clr_flags) begin
        r_overrun <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_tick && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_tick && (ch_mask != 2'b00)) begin
            r_scan_mask <= ch_mask;
            r_channel   <= first_channel(ch_mask);
            r_start     <= 1'b1;
            r_state     <= ST_START;
          end
        end
        ST_START: begin
          r_wait_cnt <= 12'd0;
          r_state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!adc_data_valid) begin
            r_wait_cnt <= 12'd0;
            r_state    <= ST_WAIT_DONE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 12'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (adc_data_valid) begin
            r_state <= ST_LATCH;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 12'd1;
          end
        end
        ST_LATCH: begin
          if (r_channel) begin
            r_ch1_data <= adc_data;
            r_ch1_new  <= 1'b1;
          end else begin
            r_ch0_data <= adc_data;
            r_ch0_new  <= 1'b1;
          end
          r_scan_mask <= w_remaining;
          // A disabled scanner finishes the channel in flight but starts no more.
          if (enable && (w_remaining != 2'b00)) begin
            r_channel <= first_channel(w_remaining);
            r_start   <= 1'b1;
            r_state   <= ST_START;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign adc_start   = r_start;
  assign adc_channel = r_channel;
  assign ch0_data    = r_ch0_data;
  assign ch1_data    = r_ch1_data;
  assign ch0_new     = r_ch0_new;
  assign ch1_new     = r_ch1_new;
  assign busy        = (r_state != ST_IDLE);
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout;

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 16'd5000, sysclk cycles per scan period (10 kHz at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT, default 12'd2000, max sysclk cycles per handshake wait.
REQ-003 Port: sysclk  in  1  50 MHz system clock; the only clock.
REQ-004 Port: rst_n  in  1  reset; synchronous, active-low.
REQ-005 Port: enable  in  1  high runs periodic scanning.
REQ-006 Port: ch_mask  in  2  bit n set = channel n included in scan.
REQ-007 Port: clr_flags  in  1  one-cycle pulse clears overrun and timeout_err.
REQ-008 Port: adc_start  out  1  one-cycle start pulse to SPI ADC interface.
REQ-009 Port: adc_channel  out  1  channel select to ADC interface.
REQ-010 Port: adc_data  in  10  converted result from ADC interface.
REQ-011 Port: adc_data_valid  in  1  ADC interface chip-select level; low = converting, high = idle and data valid.
REQ-012 Port: ch0_data, ch1_data  out  10 each  last result per channel.
REQ-013 Port: ch0_new, ch1_new  out  1 each  one-cycle strobe when matching chN_data updates.
REQ-014 Port: busy  out  1  high whenever FSM not in IDLE.
REQ-015 Port: overrun, timeout_err  out  1 each  sticky error flags.

Function
REQ-016 Period counter SHALL load SAMPLE_DIV-1, decrement each cycle while enable=1, assert sample_tick for one cycle at 0, then reload; when enable=0 it SHALL hold at SAMPLE_DIV-1.
REQ-017 FSM states SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE, LATCH.
REQ-018 IDLE: on sample_tick with ch_mask!=0, SHALL capture ch_mask into scan_mask, select lowest set channel, go START; ch_mask=0 -> tick ignored, stay IDLE.
REQ-019 START: adc_start=1 for exactly this cycle, go WAIT_BUSY.
REQ-020 adc_channel SHALL be set on entry to START and held stable until LATCH completes.
REQ-021 WAIT_BUSY: go WAIT_DONE on first cycle adc_data_valid=0.
REQ-022 WAIT_DONE: go LATCH on first cycle adc_data_valid=1.
REQ-023 LATCH: copy adc_data into ch<adc_channel>_data, pulse matching chN_new same cycle; if scan_mask has a higher unconverted channel -> START with it, else IDLE.
REQ-024 Wait counter SHALL reset on entry to WAIT_BUSY and WAIT_DONE; reaching TIMEOUT in either SHALL set timeout_err, discard result (no strobe), go IDLE.
REQ-025 sample_tick while FSM not IDLE SHALL set overrun and be dropped (no queueing).
REQ-026 enable falling mid-scan SHALL NOT abort current conversion; FSM finishes it through LATCH, then goes IDLE without starting further channels.
REQ-027 ch_mask changes mid-scan SHALL take effect at next scan only.
REQ-028 clr_flags coinciding with a flag-setting event: set SHALL win.
REQ-029 Scan order fixed: channel 0 before channel 1; both strobes never asserted in same cycle.

Reset
REQ-030 rst_n=0 at a sysclk edge SHALL force: state IDLE, period counter SAMPLE_DIV-1, wait counter 0, adc_start 0, adc_channel 0, ch0_data/ch1_data 0, ch0_new/ch1_new 0, busy 0, overrun 0, timeout_err 0.
REQ-031 Reset mid-conversion SHALL return to IDLE immediately; first post-reset start SHALL wait for the next sample_tick.

Structure
REQ-032 Shared package SHALL hold FSM state encoding (3-bit), SAMPLE_DIV/TIMEOUT defaults, and channel count constant (2).
REQ-033 Period counter SHALL be sub-module sample_tick_gen (sysclk, rst_n, enable -> sample_tick).
REQ-034 Datapath: 10-bit registers per channel, 12-bit wait counter, 16-bit period counter; no arithmetic beyond decrement/increment.

Verification
REQ-035 Bench uses SAMPLE_DIV=200, TIMEOUT=100, behavioural ADC model (cs low 20 cycles after start, result = 10'h155 ch0 / 10'h2AA ch1).
REQ-036 Scenario: enable=1, ch_mask=2'b11 -> per tick ch0_data=10'h155 then ch1_data=10'h2AA, strobes in order, one adc_start each, busy low between scans.
REQ-037 Scenario: ch_mask=2'b10 -> only channel 1 converted, adc_channel=1 throughout, ch0_new never asserted.
REQ-038 Scenario: model never drops adc_data_valid -> timeout_err=1 exactly 100 cycles after WAIT_BUSY entry, no strobe, FSM IDLE; clr_flags clears it.
REQ-039 Scenario: model holds cs low 250 cycles -> overrun=1 at next tick, dropped tick causes no extra adc_start.
REQ-040 Scenario: rst_n=0 for one cycle mid-WAIT_DONE -> all outputs at reset values next cycle; enable deasserted mid-scan -> current result latched, no further adc_start.
